// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle wide adder sequencing one 16-bit CLA slice (optional subtract: CLA_SEQ_SUB_EN)

// 16-bit carry-lookahead slice: four 4-bit lookahead groups and a second-level group carry network.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        gout,
    output logic        pout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [4:0]  gc;

    // Bit generate/propagate, group terms, group carries, then in-group carries.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (pg[0] & cin);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
        gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        sum  = p ^ c;
        cout = gc[4];
        gout = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
             | (pg[3] & pg[2] & pg[1] & gg[0]);
        pout = &pg;
    end
endmodule

module cla_seq_adder #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                op,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);
    localparam int W    = 16 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
`ifdef CLA_SEQ_SUB_EN
    logic            op_q, op_d;
`endif

    logic [W-1:0]    b_eff;
    logic [15:0]     slice_a;
    logic [15:0]     slice_b;
    logic [15:0]     slice_sum;
    logic            slice_cout;
    logic            slice_gout_unused;
    logic            slice_pout_unused;

    // Subtraction feeds the inverted B operand; the +1 comes from the preloaded carry.
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        b_eff = op_q ? ~b_q : b_q;
`else
        b_eff = b_q;
`endif
        slice_a = a_q[16*idx_q +: 16];
        slice_b = b_eff[16*idx_q +: 16];
    end

    CLA_16bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .gout (slice_gout_unused),
        .pout (slice_pout_unused)
    );

    // Next-state and datapath updates for IDLE/RUN/DONE sequencing.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef CLA_SEQ_SUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
`ifdef CLA_SEQ_SUB_EN
                    op_d    = op;
                    carry_d = op ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[16*idx_q +: 16] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[W-1] == b_eff[W-1]) && (slice_sum[15] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef CLA_SEQ_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - scoreboard bench for cla_seq_adder with directed vectors
module tb_cla_seq_adder;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef CLA_SEQ_SUB_EN
    logic         op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   seen  = 1'b0;

    cla_seq_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare each presented result once against the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: got sum %h with no pending operation", sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", sum, mon_e.s);
                chk("cout", W'(cout), W'(mon_e.c));
                chk("ovf", W'(ovf), W'(mon_e.v));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic [W-1:0] esum, input logic ecout, input logic eovf,
                          input int hold);
        int           cnt;
        logic [W-1:0] held;
        @(negedge clk);
        chk("in_ready_idle", W'(in_ready), W'(1));
        a         = ta;
        b         = tb_v;
        cin       = tcin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back('{esum, ecout, eovf});
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        cin      = ~tcin;
        cnt      = 1;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", W'(cnt), W'(WORDS + 1));
        if (hold > 0) begin
            held = sum;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == 1);
                a        = 64'h0123_4567_89AB_CDEF;
                b        = 64'h1111_1111_1111_1111;
                @(negedge clk);
                chk("bp_out_valid", W'(out_valid), W'(1));
                chk("bp_in_ready", W'(in_ready), W'(0));
                chk("bp_sum_stable", sum, held);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("retire_out_valid", W'(out_valid), W'(0));
            chk("retire_in_ready", W'(in_ready), W'(1));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        op        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", W'(in_ready), W'(1));
        chk("idle_busy", W'(busy), W'(0));

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op(64'h0001_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1,
               64'h0001_0000_0001_0001, 1'b0, 1'b0, 3);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);

        // Abort: accept at edge T, assert reset so it is sampled at edge T+2.
        @(negedge clk);
        a        = 64'h0000_0000_0000_FFFF;
        b        = 64'h0000_0000_0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_sum", sum, '0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
        op = 1'b1;
        run_op(64'h5, 64'h7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
        op = 1'b0;
        run_op(64'h5, 64'h7, 1'b1, 64'hD, 1'b0, 1'b0, 0);
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
